// File: rtl/csr_regfile_if.sv
// CSR access bus between the execute-stage SYSTEM datapath and the M-mode CSR file.
// Also carries retire/trap/mret events and the registered trap-control outputs.
interface csr_regfile_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [11:0]           csr_raddr_in;
    logic [DATA_WIDTH-1:0] csr_rdata_out;
    logic                  csr_we_in;
    logic [11:0]           csr_waddr_in;
    logic [DATA_WIDTH-1:0] csr_wdata_in;
    logic                  instret_in;
    logic                  trap_valid_in;
    logic [DATA_WIDTH-1:0] trap_pc_in;
    logic [DATA_WIDTH-1:0] trap_cause_in;
    logic                  mret_in;
    logic [DATA_WIDTH-1:0] mtvec_out;
    logic [DATA_WIDTH-1:0] mepc_out;
    logic                  mie_global_out;

    modport master (
        output csr_raddr_in, csr_we_in, csr_waddr_in, csr_wdata_in, instret_in,
        output trap_valid_in, trap_pc_in, trap_cause_in, mret_in,
        input  csr_rdata_out, mtvec_out, mepc_out, mie_global_out
    );

    modport slave (
        input  csr_raddr_in, csr_we_in, csr_waddr_in, csr_wdata_in, instret_in,
        input  trap_valid_in, trap_pc_in, trap_cause_in, mret_in,
        output csr_rdata_out, mtvec_out, mepc_out, mie_global_out
    );
endinterface

// File: rtl/csr_regfile.sv
// Machine-mode CSR storage for the RV32 core: combinational read port, registered writes,
// cycle/instret counters and trap/mret state updates.
module csr_regfile #(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           HART_ID     = 0,
    parameter logic [DATA_WIDTH-1:0] MISA_VALUE  = 32'h4000_0100,
    parameter logic [DATA_WIDTH-1:0] MTVEC_RESET = 32'h0000_0000
) (
    input logic          clk_in,
    input logic          reset_n_in,
    csr_regfile_if.slave bus
);
    localparam int unsigned CW = 2 * DATA_WIDTH;

    localparam logic [11:0] AddrMstatus  = 12'h300;
    localparam logic [11:0] AddrMisa     = 12'h301;
    localparam logic [11:0] AddrMie      = 12'h304;
    localparam logic [11:0] AddrMtvec    = 12'h305;
    localparam logic [11:0] AddrMscratch = 12'h340;
    localparam logic [11:0] AddrMepc     = 12'h341;
    localparam logic [11:0] AddrMcause   = 12'h342;
    localparam logic [11:0] AddrMip      = 12'h344;
    localparam logic [11:0] AddrMcycle   = 12'hB00;
    localparam logic [11:0] AddrMcycleh  = 12'hB80;
    localparam logic [11:0] AddrMinstret = 12'hB02;
    localparam logic [11:0] AddrMinstrh  = 12'hB82;
    localparam logic [11:0] AddrCycle    = 12'hC00;
    localparam logic [11:0] AddrCycleh   = 12'hC80;
    localparam logic [11:0] AddrInstret  = 12'hC02;
    localparam logic [11:0] AddrInstreth = 12'hC82;
    localparam logic [11:0] AddrMhartid  = 12'hF14;

    localparam logic [DATA_WIDTH-1:0] MieMask   = DATA_WIDTH'(32'h0000_0888);
    localparam logic [DATA_WIDTH-1:0] AlignMask = {{(DATA_WIDTH-2){1'b1}}, 2'b00};

    logic                  st_mie_q, st_mie_d;
    logic                  st_mpie_q, st_mpie_d;
    logic [DATA_WIDTH-1:0] mie_q, mie_d;
    logic [DATA_WIDTH-1:0] mtvec_q, mtvec_d;
    logic [DATA_WIDTH-1:0] mscratch_q, mscratch_d;
    logic [DATA_WIDTH-1:0] mepc_q, mepc_d;
    logic [DATA_WIDTH-1:0] mcause_q, mcause_d;
    logic [CW-1:0]         mcycle_q, mcycle_d;
    logic [CW-1:0]         minstret_q, minstret_d;

    logic wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause;
    logic wr_mcycle, wr_mcycleh, wr_minstret, wr_minstreth;

    // Read-only and unmapped addresses decode to no strobe, so those writes vanish.
    always_comb begin
        wr_mstatus   = 1'b0;
        wr_mie       = 1'b0;
        wr_mtvec     = 1'b0;
        wr_mscratch  = 1'b0;
        wr_mepc      = 1'b0;
        wr_mcause    = 1'b0;
        wr_mcycle    = 1'b0;
        wr_mcycleh   = 1'b0;
        wr_minstret  = 1'b0;
        wr_minstreth = 1'b0;
        if (bus.csr_we_in) begin
            case (bus.csr_waddr_in)
                AddrMstatus:  wr_mstatus   = 1'b1;
                AddrMie:      wr_mie       = 1'b1;
                AddrMtvec:    wr_mtvec     = 1'b1;
                AddrMscratch: wr_mscratch  = 1'b1;
                AddrMepc:     wr_mepc      = 1'b1;
                AddrMcause:   wr_mcause    = 1'b1;
                AddrMcycle:   wr_mcycle    = 1'b1;
                AddrMcycleh:  wr_mcycleh   = 1'b1;
                AddrMinstret: wr_minstret  = 1'b1;
                AddrMinstrh:  wr_minstreth = 1'b1;
                default: ;
            endcase
        end
    end

    // Priority: trap over mret over software write for mstatus/mepc/mcause.
    always_comb begin
        st_mie_d  = st_mie_q;
        st_mpie_d = st_mpie_q;
        if (bus.trap_valid_in) begin
            st_mpie_d = st_mie_q;
            st_mie_d  = 1'b0;
        end else if (bus.mret_in) begin
            st_mie_d  = st_mpie_q;
            st_mpie_d = 1'b1;
        end else if (wr_mstatus) begin
            st_mie_d  = bus.csr_wdata_in[3];
            st_mpie_d = bus.csr_wdata_in[7];
        end

        mie_d      = wr_mie      ? (bus.csr_wdata_in & MieMask)   : mie_q;
        mtvec_d    = wr_mtvec    ? (bus.csr_wdata_in & AlignMask) : mtvec_q;
        mscratch_d = wr_mscratch ? bus.csr_wdata_in               : mscratch_q;

        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        if (bus.trap_valid_in) begin
            mepc_d   = bus.trap_pc_in & AlignMask;
            mcause_d = bus.trap_cause_in;
        end else begin
            if (wr_mepc)   mepc_d   = bus.csr_wdata_in & AlignMask;
            if (wr_mcause) mcause_d = bus.csr_wdata_in;
        end

        // A write to either half replaces it and suppresses the whole 64-bit increment.
        if (wr_mcycle)       mcycle_d = {mcycle_q[CW-1:DATA_WIDTH], bus.csr_wdata_in};
        else if (wr_mcycleh) mcycle_d = {bus.csr_wdata_in, mcycle_q[DATA_WIDTH-1:0]};
        else                 mcycle_d = mcycle_q + CW'(1);

        if (wr_minstret)       minstret_d = {minstret_q[CW-1:DATA_WIDTH], bus.csr_wdata_in};
        else if (wr_minstreth) minstret_d = {bus.csr_wdata_in, minstret_q[DATA_WIDTH-1:0]};
        else if (bus.instret_in) minstret_d = minstret_q + CW'(1);
        else                   minstret_d = minstret_q;
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            st_mie_q   <= 1'b0;
            st_mpie_q  <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RESET & AlignMask;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            st_mie_q   <= st_mie_d;
            st_mpie_q  <= st_mpie_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    // Reads see only registered state; no bypass from the write port.
    always_comb begin
        bus.csr_rdata_out = '0;
        case (bus.csr_raddr_in)
            AddrMstatus: bus.csr_rdata_out =
                DATA_WIDTH'({19'b0, 2'b11, 3'b0, st_mpie_q, 3'b0, st_mie_q, 3'b0});
            AddrMisa:                 bus.csr_rdata_out = MISA_VALUE;
            AddrMie:                  bus.csr_rdata_out = mie_q;
            AddrMtvec:                bus.csr_rdata_out = mtvec_q;
            AddrMscratch:             bus.csr_rdata_out = mscratch_q;
            AddrMepc:                 bus.csr_rdata_out = mepc_q;
            AddrMcause:               bus.csr_rdata_out = mcause_q;
            AddrMip:                  bus.csr_rdata_out = '0;
            AddrMcycle, AddrCycle:    bus.csr_rdata_out = mcycle_q[DATA_WIDTH-1:0];
            AddrMcycleh, AddrCycleh:  bus.csr_rdata_out = mcycle_q[CW-1:DATA_WIDTH];
            AddrMinstret, AddrInstret: bus.csr_rdata_out = minstret_q[DATA_WIDTH-1:0];
            AddrMinstrh, AddrInstreth: bus.csr_rdata_out = minstret_q[CW-1:DATA_WIDTH];
            AddrMhartid:              bus.csr_rdata_out = DATA_WIDTH'(HART_ID);
            default:                  bus.csr_rdata_out = '0;
        endcase
    end

    assign bus.mtvec_out      = mtvec_q;
    assign bus.mepc_out       = mepc_q;
    assign bus.mie_global_out = st_mie_q;
endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile: architectural model checked every negedge plus literal pins.
module tb_csr_regfile;
    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    int   total  = 0;
    int   bad    = 0;
    bit   cmp_en = 1'b0;

    csr_regfile_if #(.DATA_WIDTH(32)) bus ();

    csr_regfile dut (
        .clk_in     (clk_in),
        .reset_n_in (rst_n),
        .bus        (bus)
    );

    always #5 clk_in = ~clk_in;

    // Architectural model state.
    bit          m_mie, m_mpie;
    logic [31:0] m_mie_reg, m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] m_cyc, m_ins;

    function automatic logic [63:0] ctr_next(input logic [63:0] cur, input bit inc,
                                             input bit wlo, input bit whi,
                                             input logic [31:0] d);
        if (wlo) return (cur & 64'hFFFF_FFFF_0000_0000) | {32'h0, d};
        if (whi) return (cur & 64'h0000_0000_FFFF_FFFF) | ({32'h0, d} << 32);
        return inc ? cur + 64'd1 : cur;
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h301: return 32'h4000_0100;
            12'h304: return m_mie_reg;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'hB00, 12'hC00: return m_cyc[31:0];
            12'hB80, 12'hC80: return m_cyc[63:32];
            12'hB02, 12'hC02: return m_ins[31:0];
            12'hB82, 12'hC82: return m_ins[63:32];
            12'hF14: return 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            m_mie <= 1'b0; m_mpie <= 1'b0; m_mie_reg <= '0; m_mtvec <= '0;
            m_mscratch <= '0; m_mepc <= '0; m_mcause <= '0; m_cyc <= '0; m_ins <= '0;
        end else begin
            if (bus.trap_valid_in) begin
                m_mepc   <= bus.trap_pc_in & ~32'd3;
                m_mcause <= bus.trap_cause_in;
                m_mpie   <= m_mie;
                m_mie    <= 1'b0;
            end else if (bus.mret_in) begin
                m_mie  <= m_mpie;
                m_mpie <= 1'b1;
            end
            if (bus.csr_we_in) begin
                case (bus.csr_waddr_in)
                    12'h300: if (!bus.trap_valid_in && !bus.mret_in) begin
                        m_mie  <= bus.csr_wdata_in[3];
                        m_mpie <= bus.csr_wdata_in[7];
                    end
                    12'h304: m_mie_reg  <= bus.csr_wdata_in & 32'h888;
                    12'h305: m_mtvec    <= bus.csr_wdata_in & ~32'd3;
                    12'h340: m_mscratch <= bus.csr_wdata_in;
                    12'h341: if (!bus.trap_valid_in) m_mepc <= bus.csr_wdata_in & ~32'd3;
                    12'h342: if (!bus.trap_valid_in) m_mcause <= bus.csr_wdata_in;
                    default: ;
                endcase
            end
            m_cyc <= ctr_next(m_cyc, 1'b1, bus.csr_we_in && bus.csr_waddr_in == 12'hB00,
                              bus.csr_we_in && bus.csr_waddr_in == 12'hB80, bus.csr_wdata_in);
            m_ins <= ctr_next(m_ins, bus.instret_in,
                              bus.csr_we_in && bus.csr_waddr_in == 12'hB02,
                              bus.csr_we_in && bus.csr_waddr_in == 12'hB82, bus.csr_wdata_in);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk_in) begin
        if (cmp_en) begin
            chk($sformatf("rdata@%h", bus.csr_raddr_in), bus.csr_rdata_out,
                model_read(bus.csr_raddr_in));
            chk("mtvec_out", bus.mtvec_out, m_mtvec);
            chk("mepc_out", bus.mepc_out, m_mepc);
            chk("mie_global_out", 32'(bus.mie_global_out), 32'(m_mie));
        end
    end

    task automatic cyc();
        @(posedge clk_in);
        #1;
        bus.csr_we_in     = 1'b0;
        bus.trap_valid_in = 1'b0;
        bus.mret_in       = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        bus.csr_we_in    = 1'b1;
        bus.csr_waddr_in = a;
        bus.csr_wdata_in = d;
    endtask

    initial begin
        logic [11:0] sweep [8];
        sweep = '{12'h301, 12'h344, 12'hF14, 12'h7FF, 12'hC00, 12'hC80, 12'hC02, 12'hC82};
        bus.csr_raddr_in  = 12'hB00;
        bus.csr_we_in     = 1'b0;
        bus.csr_waddr_in  = '0;
        bus.csr_wdata_in  = '0;
        bus.instret_in    = 1'b0;
        bus.trap_valid_in = 1'b0;
        bus.trap_pc_in    = '0;
        bus.trap_cause_in = '0;
        bus.mret_in       = 1'b0;
        #12 rst_n = 1'b1;
        cmp_en = 1'b1;

        repeat (5) @(posedge clk_in);
        @(negedge clk_in);
        chk("mcycle_after_5", bus.csr_rdata_out, 32'd5);
        #1 bus.csr_raddr_in = 12'h300;
        #1 chk("mstatus_reset", bus.csr_rdata_out, 32'h0000_1800);
        bus.csr_raddr_in = 12'h305;
        #1 chk("mtvec_reset", bus.csr_rdata_out, 32'h0);

        cyc(); wr(12'h305, 32'h8000_0103);
        @(negedge clk_in); chk("mtvec_no_bypass", bus.csr_rdata_out, 32'h0);
        cyc();
        @(negedge clk_in);
        chk("mtvec_written", bus.csr_rdata_out, 32'h8000_0100);
        chk("mtvec_out_written", bus.mtvec_out, 32'h8000_0100);

        cyc(); wr(12'h301, 32'h0); bus.csr_raddr_in = 12'h301;
        cyc();
        @(negedge clk_in); chk("misa_ro", bus.csr_rdata_out, 32'h4000_0100);

        cyc(); wr(12'hB80, 32'h0);
        cyc(); wr(12'hB00, 32'hFFFF_FFFF); bus.csr_raddr_in = 12'hB00;
        cyc();
        @(negedge clk_in); chk("mcycle_suppressed", bus.csr_rdata_out, 32'hFFFF_FFFF);
        cyc();
        @(negedge clk_in); chk("mcycle_wrap_lo", bus.csr_rdata_out, 32'h0);
        #1 bus.csr_raddr_in = 12'hB80;
        #1 chk("mcycle_carry_hi", bus.csr_rdata_out, 32'h1);

        cyc(); wr(12'h300, 32'h8);
        cyc(); bus.trap_valid_in = 1'b1; bus.trap_pc_in = 32'h1236; bus.trap_cause_in = 32'hB;
        wr(12'h341, 32'h5555); bus.csr_raddr_in = 12'h341;
        cyc();
        @(negedge clk_in);
        chk("trap_mepc", bus.csr_rdata_out, 32'h1234);
        chk("trap_mepc_out", bus.mepc_out, 32'h1234);
        chk("trap_mie_global", 32'(bus.mie_global_out), 32'h0);
        #1 bus.csr_raddr_in = 12'h342;
        #1 chk("trap_mcause", bus.csr_rdata_out, 32'hB);
        bus.csr_raddr_in = 12'h300;
        #1 chk("trap_mstatus", bus.csr_rdata_out, 32'h1880);

        cyc(); bus.mret_in = 1'b1; wr(12'h300, 32'h0);
        cyc();
        @(negedge clk_in);
        chk("mret_mstatus", bus.csr_rdata_out, 32'h1888);
        chk("mret_mie_global", 32'(bus.mie_global_out), 32'h1);

        cyc(); wr(12'h340, 32'h11);
        cyc(); wr(12'h340, 32'h22); bus.csr_raddr_in = 12'h340;
        @(negedge clk_in); chk("mscratch_old", bus.csr_rdata_out, 32'h11);
        cyc();
        @(negedge clk_in); chk("mscratch_new", bus.csr_rdata_out, 32'h22);

        cyc(); wr(12'h304, 32'hFFFF_FFFF); bus.csr_raddr_in = 12'h304;
        cyc();
        @(negedge clk_in); chk("mie_mask", bus.csr_rdata_out, 32'h888);

        cyc(); bus.instret_in = 1'b1; bus.csr_raddr_in = 12'hB02;
        repeat (3) @(posedge clk_in);
        #2 chk("minstret_count", bus.csr_rdata_out, 32'd3);
        #1 rst_n = 1'b0;
        #1 chk("minstret_async_clear", bus.csr_rdata_out, 32'h0);
        repeat (2) begin
            @(posedge clk_in);
            #1 chk("minstret_held", bus.csr_rdata_out, 32'h0);
        end
        @(negedge clk_in);
        #1 rst_n = 1'b1;

        foreach (sweep[i]) begin
            cyc();
            bus.csr_raddr_in = sweep[i];
        end
        cyc();
        bus.instret_in = 1'b0;
        repeat (3) cyc();
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
